controlador_ataque: RTL and testbench

//  Sequences the attack phase of the 5x7 battleship game. Loads the saved board when

---
 rtl/controlador_ataque_if.sv | 41 ++++
 rtl/controlador_ataque.sv | 270 +++++++++++++++++++++++++++
 tb/tb_controlador_ataque.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_ataque_if.sv
// Game-side signal bundle of the attack controller: player inputs, saved board,
// LED matrix columns and score/status outputs.
interface controlador_ataque_if;
   logic       ligado;
   logic       modo;
   logic       confirmar_ataque;
   logic [2:0] ataque_colunas;
   logic [2:0] ataque_linhas;
   logic [6:0] coluna1_salvo;
   logic [6:0] coluna2_salvo;
   logic [6:0] coluna3_salvo;
   logic [6:0] coluna4_salvo;
   logic [6:0] coluna5_salvo;
   logic [6:0] coluna1_saida;
   logic [6:0] coluna2_saida;
   logic [6:0] coluna3_saida;
   logic [6:0] coluna4_saida;
   logic [6:0] coluna5_saida;
   logic [5:0] acertos;
   logic [5:0] tentativas;
   logic       acerto;
   logic       erro;
   logic       ataque_invalido;
   logic       fim_jogo;

   // Player / board side: drives the controls, reads the display and score.
   modport master (
      output ligado, modo, confirmar_ataque, ataque_colunas, ataque_linhas,
      output coluna1_salvo, coluna2_salvo, coluna3_salvo, coluna4_salvo, coluna5_salvo,
      input  coluna1_saida, coluna2_saida, coluna3_saida, coluna4_saida, coluna5_saida,
      input  acertos, tentativas, acerto, erro, ataque_invalido, fim_jogo
   );

   // Controller side.
   modport slave (
      input  ligado, modo, confirmar_ataque, ataque_colunas, ataque_linhas,
      input  coluna1_salvo, coluna2_salvo, coluna3_salvo, coluna4_salvo, coluna5_salvo,
      output coluna1_saida, coluna2_saida, coluna3_saida, coluna4_saida, coluna5_saida,
      output acertos, tentativas, acerto, erro, ataque_invalido, fim_jogo
   );
endinterface

// File: rtl/controlador_ataque.sv
// Attack-phase sequencer of the 5x7 battleship game. Loads the saved board,
// serves one attack per confirm press, keeps the attack map and the score,
// and drives the active-low LED matrix. All outputs come straight from flops.
module controlador_ataque #(
   parameter int FEEDBACK_CICLOS = 25_000_000,
   parameter int PISCA_CICLOS    = 12_500_000,
   parameter int SYNC_ESTAGIOS   = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   controlador_ataque_if.slave   bus
);

   localparam int FB_W = $clog2(FEEDBACK_CICLOS + 1);
   localparam int PI_W = $clog2(PISCA_CICLOS + 1);
   localparam logic [FB_W-1:0] FB_ULTIMO = FB_W'(FEEDBACK_CICLOS - 1);
   localparam logic [PI_W-1:0] PI_ULTIMO = PI_W'(PISCA_CICLOS - 1);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      CARREGAR = 3'd1,
      ESPERA   = 3'd2,
      VERIFICA = 3'd3,
      FEEDBACK = 3'd4,
      FIM      = 3'd5
   } estado_t;

   // Number of ship cells (zero bits) on a 35-cell board.
   function automatic logic [5:0] conta_navios(input logic [34:0] b);
      logic [5:0] n;
      n = 6'd0;
      for (int i = 0; i < 35; i++) begin
         if (!b[i]) begin
            n = n + 6'd1;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   estado_t                  estado_r, estado_n;
   logic [SYNC_ESTAGIOS-1:0] sync_r;
   logic                     anterior_r;
   logic                     borda_s;
   logic [34:0]              tabuleiro_r, tabuleiro_n;
   logic [34:0]              mapa_r, mapa_n;
   logic [5:0]               total_navios_r, total_navios_n;
   logic [5:0]               acertos_r, acertos_n;
   logic [5:0]               tentativas_r, tentativas_n;
   logic [2:0]               col_r, col_n;
   logic [2:0]               lin_r, lin_n;
   logic [FB_W-1:0]          fb_cnt_r, fb_cnt_n;
   logic [PI_W-1:0]          pisca_cnt_r, pisca_cnt_n;
   logic                     fase_r, fase_n;
   logic                     acerto_r, acerto_n;
   logic                     erro_r, erro_n;
   logic                     invalido_r, invalido_n;
   logic                     fim_r;
   logic [34:0]              saida_r, saida_n;
   logic [34:0]              salvo_s;
   logic                     jogo_ativo_s;
   logic                     alvo_valido_s;
   logic [5:0]               idx_s;
   logic                     ja_atacado_s;

   // Column c of the board occupies bits c*7 .. c*7+6, row r at offset r.
   assign salvo_s      = {bus.coluna5_salvo, bus.coluna4_salvo, bus.coluna3_salvo,
                          bus.coluna2_salvo, bus.coluna1_salvo};
   assign jogo_ativo_s = bus.ligado & bus.modo;
   assign borda_s      = sync_r[SYNC_ESTAGIOS-1] & ~anterior_r;
   assign alvo_valido_s = (col_r <= 3'd4) && (lin_r <= 3'd6);
   assign idx_s        = (6'(col_r) * 6'd7) + 6'(lin_r);

   // Look up the attack map only for in-range targets.
   always_comb begin
      ja_atacado_s = 1'b0;
      if (alvo_valido_s) begin
         ja_atacado_s = mapa_r[idx_s];
      end else begin
         ja_atacado_s = 1'b0;
      end
   end

   // Synchronise the raw confirm button and keep the previous sample for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_r     <= '0;
         anterior_r <= 1'b0;
      end else begin
         sync_r     <= {sync_r[SYNC_ESTAGIOS-2:0], bus.confirmar_ataque};
         anterior_r <= sync_r[SYNC_ESTAGIOS-1];
      end
   end

   // Free-running blink timebase: phase flips every PISCA_CICLOS cycles.
   always_comb begin
      pisca_cnt_n = pisca_cnt_r;
      fase_n      = fase_r;
      if (pisca_cnt_r == PI_ULTIMO) begin
         pisca_cnt_n = '0;
         fase_n      = ~fase_r;
      end else begin
         pisca_cnt_n = pisca_cnt_r + PI_W'(1);
         fase_n      = fase_r;
      end
   end

   // Next-state and next-score logic of the attack sequencer.
   always_comb begin
      estado_n       = estado_r;
      tabuleiro_n    = tabuleiro_r;
      mapa_n         = mapa_r;
      total_navios_n = total_navios_r;
      acertos_n      = acertos_r;
      tentativas_n   = tentativas_r;
      col_n          = col_r;
      lin_n          = lin_r;
      fb_cnt_n       = fb_cnt_r;
      acerto_n       = 1'b0;
      erro_n         = 1'b0;
      invalido_n     = 1'b0;
      if (!jogo_ativo_s) begin
         // Power or mode drop aborts the game from any state.
         estado_n     = OCIOSO;
         mapa_n       = '0;
         acertos_n    = 6'd0;
         tentativas_n = 6'd0;
         fb_cnt_n     = '0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               mapa_n       = '0;
               acertos_n    = 6'd0;
               tentativas_n = 6'd0;
               estado_n     = CARREGAR;
            end
            CARREGAR: begin
               tabuleiro_n    = salvo_s;
               total_navios_n = conta_navios(salvo_s);
               if (conta_navios(salvo_s) == 6'd0) begin
                  estado_n = FIM;
               end else begin
                  estado_n = ESPERA;
               end
            end
            ESPERA: begin
               if (borda_s) begin
                  col_n    = bus.ataque_colunas;
                  lin_n    = bus.ataque_linhas;
                  estado_n = VERIFICA;
               end else begin
                  estado_n = ESPERA;
               end
            end
            VERIFICA: begin
               if (!alvo_valido_s || ja_atacado_s) begin
                  invalido_n = 1'b1;
                  estado_n   = ESPERA;
               end else begin
                  mapa_n[idx_s] = 1'b1;
                  tentativas_n  = tentativas_r + 6'd1;
                  if (!tabuleiro_r[idx_s]) begin
                     acertos_n = acertos_r + 6'd1;
                     acerto_n  = 1'b1;
                  end else begin
                     erro_n = 1'b1;
                  end
                  fb_cnt_n = '0;
                  estado_n = FEEDBACK;
               end
            end
            FEEDBACK: begin
               // Confirm edges seen here are simply ignored.
               if (fb_cnt_r == FB_ULTIMO) begin
                  fb_cnt_n = '0;
                  if (acertos_r == total_navios_r) begin
                     estado_n = FIM;
                  end else begin
                     estado_n = ESPERA;
                  end
               end else begin
                  fb_cnt_n = fb_cnt_r + FB_W'(1);
               end
            end
            FIM: begin
               estado_n = FIM;
            end
            default: begin
               estado_n = OCIOSO;
            end
         endcase
      end
   end

   // Matrix image for the state being entered, so the display moves with the state.
   always_comb begin
      saida_n = '1;
      case (estado_n)
         ESPERA, VERIFICA, FEEDBACK: begin
            for (int i = 0; i < 35; i++) begin
               if (mapa_n[i]) begin
                  // Hit stays lit; miss is lit only while the blink phase is 1.
                  saida_n[i] = tabuleiro_n[i] ? ~fase_n : 1'b0;
               end else begin
                  saida_n[i] = 1'b1;
               end
            end
         end
         FIM: begin
            saida_n = tabuleiro_n;
         end
         default: begin
            saida_n = '1;
         end
      endcase
   end

   // State, game data and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_r       <= OCIOSO;
         tabuleiro_r    <= '1;
         mapa_r         <= '0;
         total_navios_r <= 6'd0;
         acertos_r      <= 6'd0;
         tentativas_r   <= 6'd0;
         col_r          <= 3'd0;
         lin_r          <= 3'd0;
         fb_cnt_r       <= '0;
         pisca_cnt_r    <= '0;
         fase_r         <= 1'b0;
         acerto_r       <= 1'b0;
         erro_r         <= 1'b0;
         invalido_r     <= 1'b0;
         fim_r          <= 1'b0;
         saida_r        <= '1;
      end else begin
         estado_r       <= estado_n;
         tabuleiro_r    <= tabuleiro_n;
         mapa_r         <= mapa_n;
         total_navios_r <= total_navios_n;
         acertos_r      <= acertos_n;
         tentativas_r   <= tentativas_n;
         col_r          <= col_n;
         lin_r          <= lin_n;
         fb_cnt_r       <= fb_cnt_n;
         pisca_cnt_r    <= pisca_cnt_n;
         fase_r         <= fase_n;
         acerto_r       <= acerto_n;
         erro_r         <= erro_n;
         invalido_r     <= invalido_n;
         fim_r          <= (estado_n == FIM);
         saida_r        <= saida_n;
      end
   end

   assign bus.coluna1_saida   = saida_r[6:0];
   assign bus.coluna2_saida   = saida_r[13:7];
   assign bus.coluna3_saida   = saida_r[20:14];
   assign bus.coluna4_saida   = saida_r[27:21];
   assign bus.coluna5_saida   = saida_r[34:28];
   assign bus.acertos         = acertos_r;
   assign bus.tentativas      = tentativas_r;
   assign bus.acerto          = acerto_r;
   assign bus.erro            = erro_r;
   assign bus.ataque_invalido = invalido_r;
   assign bus.fim_jogo        = fim_r;

endmodule

// File: tb/tb_controlador_ataque.sv
// Directed bench for controlador_ataque with short feedback/blink timing.
module tb_controlador_ataque;
   localparam int FB = 4;
   localparam int PI = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   controlador_ataque_if bus();

   controlador_ataque #(
      .FEEDBACK_CICLOS (FB),
      .PISCA_CICLOS    (PI),
      .SYNC_ESTAGIOS   (2)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acerto = 0;
   int n_erro   = 0;
   int n_inv    = 0;
   int cyc      = 0;
   int d_acerto, d_erro, d_inv;
   int s_acerto, s_erro, s_inv;
   logic       fase_esp;
   logic [6:0] blink_esp;

   // Count high cycles of each pulse output.
   always @(negedge clock) begin
      if (bus.acerto === 1'b1) n_acerto <= n_acerto + 1;
      if (bus.erro === 1'b1) n_erro <= n_erro + 1;
      if (bus.ataque_invalido === 1'b1) n_inv <= n_inv + 1;
   end

   // Clock edges since reset release, used to predict the blink phase.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_saidas(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                               input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
      check({tag, ".c1"}, 32'(bus.coluna1_saida), 32'(e1));
      check({tag, ".c2"}, 32'(bus.coluna2_saida), 32'(e2));
      check({tag, ".c3"}, 32'(bus.coluna3_saida), 32'(e3));
      check({tag, ".c4"}, 32'(bus.coluna4_saida), 32'(e4));
      check({tag, ".c5"}, 32'(bus.coluna5_saida), 32'(e5));
   endtask

   task automatic load_board(input logic [6:0] b1, input logic [6:0] b2, input logic [6:0] b3,
                             input logic [6:0] b4, input logic [6:0] b5);
      bus.coluna1_salvo = b1;
      bus.coluna2_salvo = b2;
      bus.coluna3_salvo = b3;
      bus.coluna4_salvo = b4;
      bus.coluna5_salvo = b5;
   endtask

   // One-cycle button press spanning exactly one rising edge.
   task automatic press_pulse(input logic [2:0] c, input logic [2:0] r);
      bus.ataque_colunas   = c;
      bus.ataque_linhas    = r;
      bus.confirmar_ataque = 1'b1;
      tick(1);
      bus.confirmar_ataque = 1'b0;
   endtask

   // Press, let the attack and any feedback finish, record pulse counts.
   task automatic attack(input logic [2:0] c, input logic [2:0] r);
      s_acerto = n_acerto;
      s_erro   = n_erro;
      s_inv    = n_inv;
      press_pulse(c, r);
      tick(11);
      d_acerto = n_acerto - s_acerto;
      d_erro   = n_erro - s_erro;
      d_inv    = n_inv - s_inv;
   endtask

   initial begin
      bus.ligado           = 1'b0;
      bus.modo             = 1'b0;
      bus.confirmar_ataque = 1'b0;
      bus.ataque_colunas   = 3'd0;
      bus.ataque_linhas    = 3'd0;
      load_board(7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'h7F);
      tick(2);

      // Reset values while reset is held.
      check_saidas("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      check("rst.acertos", 32'(bus.acertos), 32'd0);
      check("rst.tentativas", 32'(bus.tentativas), 32'd0);
      check("rst.pulses", 32'({bus.acerto, bus.erro, bus.ataque_invalido}), 32'd0);
      check("rst.fim", 32'(bus.fim_jogo), 32'd0);
      reset_n = 1'b1;

      // Game A: single ship at (2,3).
      bus.ligado = 1'b1;
      bus.modo   = 1'b1;
      tick(3);
      attack(3'd2, 3'd3);
      check("t1.acerto_pulse", 32'(d_acerto), 32'd1);
      check("t1.erro_pulse", 32'(d_erro), 32'd0);
      check("t1.acertos", 32'(bus.acertos), 32'd1);
      check("t1.tentativas", 32'(bus.tentativas), 32'd1);
      check("t1.fim", 32'(bus.fim_jogo), 32'd1);
      check_saidas("t1.fim_disp", 7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'h7F);

      // Mode drop clears the game on the next edge.
      bus.modo = 1'b0;
      tick(1);
      check("a.off.fim", 32'(bus.fim_jogo), 32'd0);
      check("a.off.acertos", 32'(bus.acertos), 32'd0);
      check("a.off.tentativas", 32'(bus.tentativas), 32'd0);
      check("a.off.c3", 32'(bus.coluna3_saida), 32'h7F);

      // Game B: ships at (2,3) and (4,6).
      load_board(7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'b0111111);
      bus.modo = 1'b1;
      tick(3);
      attack(3'd0, 3'd0);
      check("t2.erro_pulse", 32'(d_erro), 32'd1);
      check("t2.acerto_pulse", 32'(d_acerto), 32'd0);
      check("t2.tentativas", 32'(bus.tentativas), 32'd1);
      check("t2.acertos", 32'(bus.acertos), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         fase_esp  = ((cyc / PI) % 2) == 1;
         blink_esp = {6'b111111, ~fase_esp};
         check("t2.blink_c1", 32'(bus.coluna1_saida), 32'(blink_esp));
      end

      // Invalid attacks: repeat, column out of range, row out of range.
      attack(3'd0, 3'd0);
      check("t3.rep_inv", 32'(d_inv), 32'd1);
      check("t3.rep_erro", 32'(d_erro), 32'd0);
      check("t3.rep_tent", 32'(bus.tentativas), 32'd1);
      attack(3'd5, 3'd0);
      check("t3.col5_inv", 32'(d_inv), 32'd1);
      attack(3'd1, 3'd7);
      check("t3.row7_inv", 32'(d_inv), 32'd1);
      check("t3.tent", 32'(bus.tentativas), 32'd1);
      check("t3.acertos", 32'(bus.acertos), 32'd0);

      // Press during FEEDBACK is dropped; a later press is served.
      s_acerto = n_acerto;
      s_erro   = n_erro;
      s_inv    = n_inv;
      press_pulse(3'd1, 3'd0);
      tick(2);
      press_pulse(3'd1, 3'd1);
      tick(12);
      check("t4.erro_once", 32'(n_erro - s_erro), 32'd1);
      check("t4.no_acerto", 32'(n_acerto - s_acerto), 32'd0);
      check("t4.no_inv", 32'(n_inv - s_inv), 32'd0);
      check("t4.tent", 32'(bus.tentativas), 32'd2);
      attack(3'd1, 3'd1);
      check("t4.served_erro", 32'(d_erro), 32'd1);
      check("t4.served_tent", 32'(bus.tentativas), 32'd3);

      // Corner ship (4,6): hit, game continues.
      attack(3'd4, 3'd6);
      check("corner.acerto", 32'(d_acerto), 32'd1);
      check("corner.acertos", 32'(bus.acertos), 32'd1);
      check("corner.tent", 32'(bus.tentativas), 32'd4);
      check("corner.fim", 32'(bus.fim_jogo), 32'd0);
      check("corner.c5", 32'(bus.coluna5_saida), 32'h3F);

      // Mode drop in FEEDBACK.
      press_pulse(3'd1, 3'd2);
      tick(4);
      check("t5.fb_tent", 32'(bus.tentativas), 32'd5);
      bus.modo = 1'b0;
      tick(1);
      check("t5.off_tent", 32'(bus.tentativas), 32'd0);
      check("t5.off_acertos", 32'(bus.acertos), 32'd0);
      check_saidas("t5.off", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      bus.modo = 1'b1;
      tick(3);
      attack(3'd0, 3'd0);
      check("t5.fresh_erro", 32'(d_erro), 32'd1);
      check("t5.fresh_inv", 32'(d_inv), 32'd0);
      check("t5.fresh_tent", 32'(bus.tentativas), 32'd1);

      // All-water board ends immediately after loading.
      bus.ligado = 1'b0;
      tick(1);
      load_board(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      bus.ligado = 1'b1;
      tick(1);
      check("t5.water_load_fim", 32'(bus.fim_jogo), 32'd0);
      tick(1);
      check("t5.water_fim", 32'(bus.fim_jogo), 32'd1);
      check_saidas("t5.water", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      attack(3'd0, 3'd0);
      check("t5.fim_no_pulse", 32'(d_acerto + d_erro + d_inv), 32'd0);
      check("t5.fim_tent", 32'(bus.tentativas), 32'd0);

      // Asynchronous reset in ESPERA.
      bus.ligado = 1'b0;
      tick(1);
      load_board(7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'b0111111);
      bus.ligado = 1'b1;
      tick(3);
      attack(3'd2, 3'd3);
      check("t6.pre_acertos", 32'(bus.acertos), 32'd1);
      check("t6.pre_c3", 32'(bus.coluna3_saida), 32'b1110111);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6.async_acertos", 32'(bus.acertos), 32'd0);
      check("t6.async_tent", 32'(bus.tentativas), 32'd0);
      check("t6.async_fim", 32'(bus.fim_jogo), 32'd0);
      check_saidas("t6.async", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      tick(2);
      reset_n = 1'b1;
      tick(3);
      check("t6.after_acertos", 32'(bus.acertos), 32'd0);
      check("t6.after_c3", 32'(bus.coluna3_saida), 32'h7F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
